shift_cmd_ctrl: RTL and testbench

- Command sequencer directly upstream of the variable shifter (the `var_shift` register stage).
- Buffers shift commands (direction, amount, fill data) in a small FIFO and drives the shifter's en/dir/shift/in pins one command at a time.
- Captures the shifter's registered output q and returns it on a valid/ready result channel.
- Turns the free-running shifter into a flow-controlled pipeline stage.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_cmd_fifo.sv | 46 ++++
 rtl/var_shift.sv | 32 +++
 rtl/shift_cmd_ctrl.sv | 144 ++++++++++++++
 tb/tb_shift_cmd_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared constants, FSM state type and command payload for the shift command sequencer.
package shift_pkg;

   localparam int unsigned W_DEF     = 32;
   localparam int unsigned SW_DEF    = 6;
   localparam int unsigned SHIFT_MAX = W_DEF - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CAPT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef struct packed {
      logic              dir;
      logic [SW_DEF-1:0] shift;
      logic [W_DEF-1:0]  data;
      logic              err;
   } cmd_t;

endpackage

// File: rtl/shift_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two, pointers carry an extra wrap bit.
module shift_cmd_fifo
   import shift_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic push,
   input  logic pop,
   input  cmd_t wdata,
   output cmd_t rdata_c,
   output logic full_c,
   output logic empty_c
);

   localparam int unsigned AW = $clog2(DEPTH);

   cmd_t        mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        wr_en_c;
   logic        rd_en_c;

   assign wr_en_c = push & ~full_c;
   assign rd_en_c = pop & ~empty_c;
   assign empty_c = (wr_ptr == rd_ptr);
   assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata_c = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en_c) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_en_c) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: entries are only read behind a valid write pointer.
   always_ff @(posedge clk) begin
      if (wr_en_c) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/var_shift.sv
// Registered variable funnel shifter: q shifts by 'shift' and vacated bits fill from 'in'.
module var_shift #(
   parameter int unsigned W  = 32,
   parameter int unsigned SW = 6
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          en,
   input  logic          dir,
   input  logic [SW-1:0] shift,
   input  logic [W-1:0]  in,
   output logic [W-1:0]  q
);

   logic [2*W-1:0] rwide_c;
   logic [2*W-1:0] lwide_c;

   // Right shifts pull fill bits from the low end of in, left shifts from the high end.
   always_comb begin
      rwide_c = {in, q} >> shift;
      lwide_c = {q, in} << shift;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         q <= '0;
      end else if (en) begin
         q <= dir ? lwide_c[2*W-1:W] : rwide_c[W-1:0];
      end
   end

endmodule

// File: rtl/shift_cmd_ctrl.sv
// Flow-controlled command sequencer in front of var_shift; define SHIFT_CMD_STATS_EN
// to add the op_count / clamp_count statistics outputs.
module shift_cmd_ctrl
   import shift_pkg::*;
#(
   parameter int unsigned W     = W_DEF,
   parameter int unsigned SW    = SW_DEF,
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_dir,
   input  logic [SW-1:0] cmd_shift,
   input  logic [W-1:0]  cmd_data,
   output logic          sh_en,
   output logic          sh_dir,
   output logic [SW-1:0] sh_shift,
   output logic [W-1:0]  sh_in,
   input  logic [W-1:0]  sh_q,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [W-1:0]  res_data,
   output logic          res_err
`ifdef SHIFT_CMD_STATS_EN
  ,output logic [15:0]   op_count,
   output logic [7:0]    clamp_count
`endif
);

   state_e state;
   state_e state_d;
   cmd_t   push_cmd_c;
   cmd_t   head_c;
   logic   full_c;
   logic   empty_c;
   logic   push_c;
   logic   pop_c;
   logic   clamp_c;
   logic   err_q;

   assign cmd_ready = ~full_c;
   assign push_c    = cmd_valid & cmd_ready;
   assign clamp_c   = (cmd_shift > SW'(SHIFT_MAX));

   // Out-of-range amounts are clamped on entry so the shifter never sees them.
   always_comb begin
      push_cmd_c.dir   = cmd_dir;
      push_cmd_c.shift = clamp_c ? SW'(SHIFT_MAX) : cmd_shift;
      push_cmd_c.data  = cmd_data;
      push_cmd_c.err   = clamp_c;
   end

   shift_cmd_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk    (clk),
      .clr    (clr),
      .push   (push_c),
      .pop    (pop_c),
      .wdata  (push_cmd_c),
      .rdata_c(head_c),
      .full_c (full_c),
      .empty_c(empty_c)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= IDLE;
      else      state <= state_d;
   end

   always_comb begin
      state_d = state;
      pop_c   = 1'b0;
      case (state)
         IDLE: begin
            if (!empty_c) begin
               pop_c   = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = CAPT;
         CAPT:  state_d = RESP;
         RESP: begin
            if (res_ready) begin
               if (!empty_c) begin
                  pop_c   = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Every pop lands in ISSUE next cycle, so sh_en is set only for that one cycle.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         sh_en    <= 1'b0;
         sh_dir   <= 1'b0;
         sh_shift <= '0;
         sh_in    <= '0;
         err_q    <= 1'b0;
      end else begin
         sh_en <= pop_c && (head_c.shift != '0);
         if (pop_c) begin
            sh_dir   <= head_c.dir;
            sh_shift <= head_c.shift;
            sh_in    <= head_c.data;
            err_q    <= head_c.err;
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_err   <= 1'b0;
      end else begin
         res_valid <= (state_d == RESP);
         if (state == CAPT) begin
            res_data <= sh_q;
            res_err  <= err_q;
         end
      end
   end

`ifdef SHIFT_CMD_STATS_EN
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         op_count    <= '0;
         clamp_count <= '0;
      end else begin
         if (res_valid && res_ready) op_count <= op_count + 16'd1;
         if (push_c && clamp_c && (clamp_count != 8'hFF)) clamp_count <= clamp_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_shift_cmd_ctrl.sv
// Directed bench for shift_cmd_ctrl driving var_shift, with an in-order result scoreboard.
module tb_shift_cmd_ctrl;
   import shift_pkg::*;

   localparam int unsigned W     = W_DEF;
   localparam int unsigned SW    = SW_DEF;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [W-1:0] data;
      logic         err;
   } exp_t;

   logic          clk       = 1'b0;
   logic          clr       = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_dir   = 1'b0;
   logic [SW-1:0] cmd_shift = '0;
   logic [W-1:0]  cmd_data  = '0;
   logic          sh_en;
   logic          sh_dir;
   logic [SW-1:0] sh_shift;
   logic [W-1:0]  sh_in;
   logic [W-1:0]  sh_q;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [W-1:0]  res_data;
   logic          res_err;
`ifdef SHIFT_CMD_STATS_EN
   logic [15:0]   op_count;
   logic [7:0]    clamp_count;
`endif

   int           checks   = 0;
   int           failures = 0;
   int           cyc      = 0;
   int           en_cnt   = 0;
   exp_t         exp_q[$];
   int           hs_cyc[$];
   logic [W-1:0] model_q  = '0;

   always #5 clk = ~clk;

   shift_cmd_ctrl #(.W(W), .SW(SW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .clr      (clr),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_dir  (cmd_dir),
      .cmd_shift(cmd_shift),
      .cmd_data (cmd_data),
      .sh_en    (sh_en),
      .sh_dir   (sh_dir),
      .sh_shift (sh_shift),
      .sh_in    (sh_in),
      .sh_q     (sh_q),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_data (res_data),
      .res_err  (res_err)
`ifdef SHIFT_CMD_STATS_EN
     ,.op_count   (op_count),
      .clamp_count(clamp_count)
`endif
   );

   var_shift #(.W(W), .SW(SW)) u_shifter (
      .clk  (clk),
      .clr  (clr),
      .en   (sh_en),
      .dir  (sh_dir),
      .shift(sh_shift),
      .in   (sh_in),
      .q    (sh_q)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] shift_model(input logic [W-1:0] q, input logic dir,
                                                input int s, input logic [W-1:0] fill);
      if (s == 0) return q;
      if (dir) return (q << s) | (fill >> (W - s));
      return (q >> s) | (fill << (W - s));
   endfunction

   // Scoreboard: a handshake is seen at the falling edge before the edge that completes it.
   always @(negedge clk) begin
      if (clr && sh_en) en_cnt++;
      if (clr && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'(exp_q.size()), 32'd1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("res_data", res_data, e.data);
            chk("res_err", 32'(res_err), 32'(e.err));
            hs_cyc.push_back(cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic d, input logic [SW-1:0] s, input logic [W-1:0] data);
      int eff;
      cmd_valid = 1'b1;
      cmd_dir   = d;
      cmd_shift = s;
      cmd_data  = data;
      for (int k = 0; k < 50; k++) begin
         if (cmd_ready) break;
         step();
      end
      if (!cmd_ready) begin
         chk("push_timeout", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      step();
      cmd_valid = 1'b0;
      eff       = (int'(s) > int'(W) - 1) ? int'(W) - 1 : int'(s);
      model_q   = shift_model(model_q, d, eff, data);
      exp_q.push_back('{data: model_q, err: (int'(s) > int'(W) - 1)});
   endtask

   task automatic wait_valid(input string tag);
      for (int k = 0; k < 20; k++) begin
         if (res_valid) break;
         step();
      end
      if (!res_valid) chk(tag, 32'(res_valid), 32'd1);
   endtask

   task automatic take_result();
      res_ready = 1'b1;
      wait_valid("take_timeout");
      step();
      res_ready = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 80; k++) begin
         if (exp_q.size() == 0 && !res_valid) break;
         step();
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_spacing(input string tag, input int n);
      chk({tag, "_count"}, 32'(hs_cyc.size()), 32'(n));
      for (int i = 1; i < hs_cyc.size(); i++)
         chk({tag, "_gap"}, 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);
   endtask

   initial begin
      int c0;
      int en0;
      logic seen_valid;

      // Reset
      #1 clr = 1'b0;
      #2;
      chk("rst_sh_en", 32'(sh_en), 32'd0);
      chk("rst_sh_dir", 32'(sh_dir), 32'd0);
      chk("rst_sh_shift", 32'(sh_shift), 32'd0);
      chk("rst_sh_in", sh_in, 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_res_err", 32'(res_err), 32'd0);
      step();
      step();
      clr = 1'b1;
      step();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef SHIFT_CMD_STATS_EN
      chk("rst_op_count", 32'(op_count), 32'd0);
      chk("rst_clamp_count", 32'(clamp_count), 32'd0);
`endif

      // Prime shifter q to F000_0000 via a right shift by 31
      push_cmd(1'b0, 6'd31, 32'h7800_0000);
      take_result();
      chk("prime_q", res_data, 32'hF000_0000);

      // Single right shift; push cycle counts as cycle 0 of the 4-cycle latency
      en0 = en_cnt;
      push_cmd(1'b0, 6'd4, 32'h0000_000A);
      c0 = cyc;
      wait_valid("single_timeout");
      chk("single_latency", 32'(cyc - c0), 32'd3);
      chk("single_en_cycles", 32'(en_cnt - en0), 32'd1);
      chk("single_sh_shift", 32'(sh_shift), 32'd4);
      take_result();
      chk("single_res", res_data, 32'hAF00_0000);

      // Zero shift leaves q unchanged and never enables the shifter
      en0 = en_cnt;
      push_cmd(1'b1, 6'd0, 32'h1234_5678);
      c0 = cyc;
      wait_valid("zero_timeout");
      chk("zero_latency", 32'(cyc - c0), 32'd3);
      chk("zero_en_cycles", 32'(en_cnt - en0), 32'd0);
      take_result();
      chk("zero_res", res_data, 32'hAF00_0000);

      // Clamp: 40 becomes 31 with err set
      push_cmd(1'b1, 6'd40, 32'hDEAD_BEEF);
      wait_valid("clamp_timeout");
      chk("clamp_sh_shift", 32'(sh_shift), 32'd31);
      take_result();
      chk("clamp_res", res_data, 32'h6F56_DF77);
      chk("clamp_err", 32'(res_err), 32'd1);
`ifdef SHIFT_CMD_STATS_EN
      chk("clamp_count", 32'(clamp_count), 32'd1);
      chk("op_count_4", 32'(op_count), 32'd4);
`endif

      // Full FIFO under backpressure
      hs_cyc.delete();
      push_cmd(1'b0, 6'd1, 32'h1111_1111);
      push_cmd(1'b1, 6'd2, 32'h2222_2222);
      push_cmd(1'b0, 6'd0, 32'h3333_3333);
      push_cmd(1'b1, 6'd7, 32'h4444_4444);
      push_cmd(1'b0, 6'd13, 32'h5555_5555);
      chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
      for (int k = 0; k < 4; k++) step();
      chk("full_hold_ready", 32'(cmd_ready), 32'd0);
      chk("full_resp_valid", 32'(res_valid), 32'd1);
      res_ready = 1'b1;
      push_cmd(1'b1, 6'd20, 32'h6666_6666);
      drain("full_drain");
      res_ready = 1'b0;
      chk_spacing("full", 6);

      // Back-to-back with res_ready held high
      hs_cyc.delete();
      res_ready = 1'b1;
      push_cmd(1'b0, 6'd3, 32'hA5A5_A5A5);
      c0 = cyc;
      push_cmd(1'b1, 6'd9, 32'h0F0F_0F0F);
      push_cmd(1'b0, 6'd16, 32'hCAFE_F00D);
      drain("b2b_drain");
      res_ready = 1'b0;
      chk_spacing("b2b", 3);
      if (hs_cyc.size() > 0) chk("b2b_first", 32'(hs_cyc[0] - c0), 32'd3);

      // Reset during ISSUE with two commands still queued
      push_cmd(1'b0, 6'd2, 32'h0000_0001);
      push_cmd(1'b1, 6'd5, 32'h0000_0002);
      push_cmd(1'b0, 6'd6, 32'h0000_0003);
      push_cmd(1'b1, 6'd8, 32'h0000_0004);
      wait_valid("midrst_timeout");
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("midrst_issue_en", 32'(sh_en), 32'd1);
      clr = 1'b0;
      #1;
      chk("midrst_res_valid", 32'(res_valid), 32'd0);
      chk("midrst_sh_en", 32'(sh_en), 32'd0);
      exp_q.delete();
      model_q = '0;
      step();
      clr = 1'b1;
      step();
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      en0        = en_cnt;
      seen_valid = 1'b0;
      res_ready  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (res_valid) seen_valid = 1'b1;
         step();
      end
      res_ready = 1'b0;
      chk("midrst_no_stale", 32'(seen_valid), 32'd0);
      chk("midrst_no_issue", 32'(en_cnt - en0), 32'd0);
`ifdef SHIFT_CMD_STATS_EN
      chk("midrst_op_count", 32'(op_count), 32'd0);
`endif

      // Operation resumes cleanly after reset
      push_cmd(1'b0, 6'd8, 32'h0000_00FF);
      take_result();
      chk("post_rst_res", res_data, 32'hFF00_0000);
`ifdef SHIFT_CMD_STATS_EN
      chk("post_rst_op_count", 32'(op_count), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
